id_exe_pipe_reg: RTL

Pipeline register between the decode stage and the execute stage of the ARM pipeline. It captures the two register-file read operands (Rn, Rm), the decoded control word, the immediates, and the current NZCV status on each rising clock edge. It also supports memory-stall freeze, branch flush, and hazard bubble insertion. A saturating bubble counter is provided for performance debug.

---
 rtl/arm_pkg.sv | 34 +++
 rtl/sat_counter.sv | 29 ++
 rtl/id_exe_pipe_reg.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// ARM pipeline shared definitions: ALU command encodings, NZCV positions, ID/EXE control word.
`default_nettype none
package arm_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       b;
    logic       s;
    logic       imm;
  } id_exe_ctrl_t;

  localparam id_exe_ctrl_t ID_EXE_CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
// Saturating up-counter with hold; shared by the pipeline debug counters.
`default_nettype none
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!hold && inc && (count_q != {W{1'b1}}))
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register with freeze (hold), flush/hazard bubble insertion and bubble counter.
`default_nettype none
module id_exe_pipe_reg
  import arm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             hazard,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      val_rn_in,
  input  logic [31:0]      val_rm_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             wb_en_in,
  input  logic             b_in,
  input  logic             s_in,
  input  logic             imm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm24_in,
  input  logic [3:0]       dest_in,
  input  logic [3:0]       src1_in,
  input  logic [3:0]       src2_in,
  input  logic [3:0]       status_in,
  input  logic             valid_in,
  output logic [31:0]      pc_out,
  output logic [31:0]      val_rn_out,
  output logic [31:0]      val_rm_out,
  output logic [3:0]       exe_cmd_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic             wb_en_out,
  output logic             b_out,
  output logic             s_out,
  output logic             imm_out,
  output logic [11:0]      shift_operand_out,
  output logic [23:0]      signed_imm24_out,
  output logic [3:0]       dest_out,
  output logic [3:0]       src1_out,
  output logic [3:0]       src2_out,
  output logic [3:0]       status_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] bubble_cnt
);

  id_exe_ctrl_t ctrl_q, ctrl_d, ctrl_in;
  logic [31:0]  pc_q, pc_d, rn_q, rn_d, rm_q, rm_d;
  logic [11:0]  shop_q, shop_d;
  logic [23:0]  off_q, off_d;
  logic [3:0]   dest_q, dest_d, src1_q, src1_d, src2_q, src2_d, status_q, status_d;
  logic         valid_q, valid_d;
  logic         bubble;

  assign bubble  = flush | hazard;
  assign ctrl_in = '{exe_cmd: exe_cmd_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in,
                     wb_en: wb_en_in, b: b_in, s: s_in, imm: imm_in};

  always_comb begin
    ctrl_d   = ctrl_q;
    pc_d     = pc_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    shop_d   = shop_q;
    off_d    = off_q;
    dest_d   = dest_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    status_d = status_q;
    valid_d  = valid_q;
    if (!freeze) begin
      if (bubble) begin
        // Indices are zeroed too, so forwarding must qualify on wb_en.
        ctrl_d   = ID_EXE_CTRL_BUBBLE;
        pc_d     = '0;
        rn_d     = '0;
        rm_d     = '0;
        shop_d   = '0;
        off_d    = '0;
        dest_d   = '0;
        src1_d   = '0;
        src2_d   = '0;
        status_d = '0;
        valid_d  = 1'b0;
      end else begin
        ctrl_d   = ctrl_in;
        pc_d     = pc_in;
        rn_d     = val_rn_in;
        rm_d     = val_rm_in;
        shop_d   = shift_operand_in;
        off_d    = signed_imm24_in;
        dest_d   = dest_in;
        src1_d   = src1_in;
        src2_d   = src2_in;
        status_d = status_in;
        valid_d  = valid_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= ID_EXE_CTRL_BUBBLE;
      pc_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      shop_q   <= '0;
      off_q    <= '0;
      dest_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      status_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      pc_q     <= pc_d;
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      shop_q   <= shop_d;
      off_q    <= off_d;
      dest_q   <= dest_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      status_q <= status_d;
      valid_q  <= valid_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble),
    .hold  (freeze),
    .count (bubble_cnt)
  );

  assign exe_cmd_out       = ctrl_q.exe_cmd;
  assign mem_r_en_out      = ctrl_q.mem_r_en;
  assign mem_w_en_out      = ctrl_q.mem_w_en;
  assign wb_en_out         = ctrl_q.wb_en;
  assign b_out             = ctrl_q.b;
  assign s_out             = ctrl_q.s;
  assign imm_out           = ctrl_q.imm;
  assign pc_out            = pc_q;
  assign val_rn_out        = rn_q;
  assign val_rm_out        = rm_q;
  assign shift_operand_out = shop_q;
  assign signed_imm24_out  = off_q;
  assign dest_out          = dest_q;
  assign src1_out          = src1_q;
  assign src2_out          = src2_q;
  assign status_out        = status_q;
  assign valid_out         = valid_q;

endmodule
`default_nettype wire
